// File: rtl/ctech_lib_sync_pkg.sv
// Shared constants and helpers for the ctech_lib synchroniser family.
package ctech_lib_sync_pkg;

  localparam int unsigned SYNC_MIN_STAGES = 2;
  localparam int unsigned SYNC_MAX_STAGES = 4;
  localparam int unsigned FILT_MAX        = 255;

  // Width of a counter holding 0..n, never narrower than one bit.
  function automatic int unsigned filt_cnt_w(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ctech_lib_nsync_filt_chan.sv
// One synchroniser channel: sync chain, optional stability filter and
// registered rise/fall detection.
module ctech_lib_nsync_filt_chan
  import ctech_lib_sync_pkg::*;
#(
  parameter int unsigned STAGES   = 3,
  parameter logic        RST_VAL  = 1'b1,
  parameter int unsigned FILT_CYC = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic o,
  output logic rise,
  output logic fall,
  output logic edge_c
);

  logic [STAGES-1:0] sync_w;
  logic              y;
  logic              o_d;
  logic              rise_q;
  logic              fall_q;

  // First capture flop: the only one allowed to go metastable.
  (* async_reg = "true" *) logic meta_q;

  always_ff @(posedge clk) begin
    if (rst) meta_q <= RST_VAL;
    else     meta_q <= d;
  end

  assign sync_w[0] = meta_q;

  for (genvar k = 1; k < STAGES; k++) begin : g_stage
    logic stg_q;
    always_ff @(posedge clk) begin
      if (rst) stg_q <= RST_VAL;
      else     stg_q <= sync_w[k-1];
    end
    assign sync_w[k] = stg_q;
  end

  assign y = sync_w[STAGES-1];

  if (FILT_CYC == 0) begin : g_nofilt
    // Output is the last chain flop; its next value is the flop before it.
    assign o   = y;
    assign o_d = sync_w[STAGES-2];
  end else begin : g_filt
    localparam int unsigned   CW       = filt_cnt_w(FILT_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          o_q;

    // Count consecutive disagreeing cycles; any agreement restarts the count.
    always_comb begin
      o_d   = o_q;
      cnt_d = '0;
      if (y != o_q) begin
        if (cnt_q == CNT_LAST) o_d = y;
        else                   cnt_d = cnt_q + CW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        o_q   <= RST_VAL;
        cnt_q <= '0;
      end else begin
        o_q   <= o_d;
        cnt_q <= cnt_d;
      end
    end

    assign o = o_q;
  end

  // Edge flops update with o so pulses line up with the new level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= ~o & o_d;
      fall_q <= o & ~o_d;
    end
  end

  assign rise   = rise_q;
  assign fall   = fall_q;
  assign edge_c = o ^ o_d;

endmodule

// File: rtl/ctech_lib_nsync_filt.sv
// Multi-channel synchroniser with configurable depth, reset value,
// glitch filter and registered edge pulses.
module ctech_lib_nsync_filt
  import ctech_lib_sync_pkg::*;
#(
  parameter int unsigned      WIDTH    = 1,
  parameter int unsigned      STAGES   = 3,
  parameter logic [WIDTH-1:0] RST_VAL  = '1,
  parameter int unsigned      FILT_CYC = 0,
  parameter bit               EDGE_EN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             chg_any
);

  if (STAGES < SYNC_MIN_STAGES || STAGES > SYNC_MAX_STAGES) begin : g_bad_stages
    $error("ctech_lib_nsync_filt: STAGES must be within 2..4");
  end

  if (FILT_CYC > FILT_MAX) begin : g_bad_filt
    $error("ctech_lib_nsync_filt: FILT_CYC must be within 0..255");
  end

  localparam logic [WIDTH-1:0] EDGE_MASK = {WIDTH{EDGE_EN}};

  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;
  logic [WIDTH-1:0] edge_w;
  logic             chg_any_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    ctech_lib_nsync_filt_chan #(
      .STAGES   (STAGES),
      .RST_VAL  (RST_VAL[i]),
      .FILT_CYC (FILT_CYC)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .d      (d[i]),
      .o      (o[i]),
      .rise   (rise_w[i]),
      .fall   (fall_w[i]),
      .edge_c (edge_w[i])
    );
  end

  // Registered alongside the per-bit edge flops so all pulses coincide.
  always_ff @(posedge clk) begin
    if (rst) chg_any_q <= 1'b0;
    else     chg_any_q <= |(edge_w & EDGE_MASK);
  end

  assign rise    = rise_w & EDGE_MASK;
  assign fall    = fall_w & EDGE_MASK;
  assign chg_any = chg_any_q;

endmodule

// File: tb/tb_ctech_lib_nsync_filt.sv
// Randomised bench: several configurations of the synchroniser share one
// stimulus bus and are compared every cycle against a delay/run-length model.
module tb_ctech_lib_nsync_filt;

  localparam int NI = 7;
  localparam int         ST [NI] = '{3, 2, 4, 3, 3, 3, 3};
  localparam int         FC [NI] = '{0, 0, 0, 4, 5, 0, 2};
  localparam logic [7:0] RV [NI] = '{8'h0A, 8'h01, 8'h00, 8'h00, 8'h01, 8'hFF, 8'h00};
  localparam logic [7:0] WM [NI] = '{8'h0F, 8'h01, 8'h01, 8'h01, 8'h01, 8'hFF, 8'hFF};
  localparam bit         EE [NI] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d;

  always #5 clk = ~clk;

  logic [3:0] o0, r0, f0;
  logic       o1, r1, f1, o2, r2, f2, o3, r3, f3, o4, r4, f4;
  logic [7:0] o5, r5, f5, o6, r6, f6;
  logic       c0, c1, c2, c3, c4, c5, c6;

  ctech_lib_nsync_filt #(.WIDTH(4), .STAGES(3), .RST_VAL(4'b1010), .FILT_CYC(0), .EDGE_EN(1'b1))
    u_rv (.clk(clk), .rst(rst), .d(d[3:0]), .o(o0), .rise(r0), .fall(f0), .chg_any(c0));
  ctech_lib_nsync_filt #(.WIDTH(1), .STAGES(2), .RST_VAL(1'b1), .FILT_CYC(0), .EDGE_EN(1'b1))
    u_s2 (.clk(clk), .rst(rst), .d(d[0]), .o(o1), .rise(r1), .fall(f1), .chg_any(c1));
  ctech_lib_nsync_filt #(.WIDTH(1), .STAGES(4), .RST_VAL(1'b0), .FILT_CYC(0), .EDGE_EN(1'b1))
    u_s4 (.clk(clk), .rst(rst), .d(d[1]), .o(o2), .rise(r2), .fall(f2), .chg_any(c2));
  ctech_lib_nsync_filt #(.WIDTH(1), .STAGES(3), .RST_VAL(1'b0), .FILT_CYC(4), .EDGE_EN(1'b1))
    u_f4 (.clk(clk), .rst(rst), .d(d[2]), .o(o3), .rise(r3), .fall(f3), .chg_any(c3));
  ctech_lib_nsync_filt #(.WIDTH(1), .STAGES(3), .RST_VAL(1'b1), .FILT_CYC(5), .EDGE_EN(1'b1))
    u_f5 (.clk(clk), .rst(rst), .d(d[3]), .o(o4), .rise(r4), .fall(f4), .chg_any(c4));
  ctech_lib_nsync_filt #(.WIDTH(8), .STAGES(3), .RST_VAL(8'hFF), .FILT_CYC(0), .EDGE_EN(1'b1))
    u_w8e (.clk(clk), .rst(rst), .d(d), .o(o5), .rise(r5), .fall(f5), .chg_any(c5));
  ctech_lib_nsync_filt #(.WIDTH(8), .STAGES(3), .RST_VAL(8'h00), .FILT_CYC(2), .EDGE_EN(1'b0))
    u_w8n (.clk(clk), .rst(rst), .d(d), .o(o6), .rise(r6), .fall(f6), .chg_any(c6));

  logic [7:0] dut_o [NI];
  logic [7:0] dut_r [NI];
  logic [7:0] dut_f [NI];
  logic       dut_c [NI];

  assign dut_o[0] = {4'b0, o0};  assign dut_r[0] = {4'b0, r0};  assign dut_f[0] = {4'b0, f0};
  assign dut_o[1] = {7'b0, o1};  assign dut_r[1] = {7'b0, r1};  assign dut_f[1] = {7'b0, f1};
  assign dut_o[2] = {7'b0, o2};  assign dut_r[2] = {7'b0, r2};  assign dut_f[2] = {7'b0, f2};
  assign dut_o[3] = {7'b0, o3};  assign dut_r[3] = {7'b0, r3};  assign dut_f[3] = {7'b0, f3};
  assign dut_o[4] = {7'b0, o4};  assign dut_r[4] = {7'b0, r4};  assign dut_f[4] = {7'b0, f4};
  assign dut_o[5] = o5;          assign dut_r[5] = r5;          assign dut_f[5] = f5;
  assign dut_o[6] = o6;          assign dut_r[6] = r6;          assign dut_f[6] = f6;
  assign dut_c[0] = c0; assign dut_c[1] = c1; assign dut_c[2] = c2; assign dut_c[3] = c3;
  assign dut_c[4] = c4; assign dut_c[5] = c5; assign dut_c[6] = c6;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc_n  = 0;

  // Reference state: recent input history, expected outputs, disagreement run length.
  logic [7:0] hd [4];
  logic       hr [4];
  logic [7:0] m_o [NI];
  logic [7:0] m_y [NI];
  logic [7:0] m_r [NI];
  logic [7:0] m_f [NI];
  logic       m_c [NI];
  int         run [NI][8];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc_n, act, exp);
    end
  endtask

  function automatic logic [7:0] in_of(input int k, input logic [7:0] v);
    logic [7:0] r;
    case (k)
      0:       r = {4'b0, v[3:0]};
      1:       r = {7'b0, v[0]};
      2:       r = {7'b0, v[1]};
      3:       r = {7'b0, v[2]};
      4:       r = {7'b0, v[3]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Applies one clock edge worth of the rules to every configuration.
  task automatic model_step();
    for (int j = 3; j > 0; j--) begin
      hd[j] = hd[j-1];
      hr[j] = hr[j-1];
    end
    hd[0] = d;
    hr[0] = rst;
    for (int k = 0; k < NI; k++) begin
      logic [7:0] ynew, yold, oold, onew, msk;
      logic       anyr;
      msk  = WM[k];
      anyr = 1'b0;
      for (int j = 0; j < ST[k]; j++) anyr |= hr[j];
      ynew = anyr ? RV[k] : in_of(k, hd[ST[k]-1]);
      yold = m_y[k];
      oold = m_o[k];
      onew = oold;
      if (rst) begin
        onew = RV[k];
        for (int b = 0; b < 8; b++) run[k][b] = 0;
      end else if (FC[k] == 0) begin
        onew = ynew;
      end else begin
        for (int b = 0; b < 8; b++) begin
          if (msk[b] && (yold[b] != oold[b])) begin
            run[k][b]++;
            if (run[k][b] == FC[k]) begin
              onew[b]   = yold[b];
              run[k][b] = 0;
            end
          end else begin
            run[k][b] = 0;
          end
        end
      end
      if (rst || !EE[k]) begin
        m_r[k] = 8'h00;
        m_f[k] = 8'h00;
      end else begin
        m_r[k] = ~oold & onew & msk;
        m_f[k] = oold & ~onew & msk;
      end
      m_c[k] = |(m_r[k] | m_f[k]);
      m_o[k] = onew;
      m_y[k] = ynew;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("o_%0d", k),       32'(dut_o[k]), 32'(m_o[k]));
      chk($sformatf("rise_%0d", k),    32'(dut_r[k]), 32'(m_r[k]));
      chk($sformatf("fall_%0d", k),    32'(dut_f[k]), 32'(m_f[k]));
      chk($sformatf("chg_any_%0d", k), 32'(dut_c[k]), 32'(m_c[k]));
    end
  endtask

  // Drive at the falling edge, model at the rising edge, check at the next falling edge.
  task automatic cyc(input logic [7:0] v, input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      d   = v;
      rst = r;
      @(posedge clk);
      model_step();
      @(negedge clk);
      cyc_n++;
      check_all();
    end
  endtask

  initial begin
    logic [7:0] v;
    for (int j = 0; j < 4; j++) begin
      hd[j] = 8'h00;
      hr[j] = 1'b1;
    end
    for (int k = 0; k < NI; k++) begin
      m_o[k] = RV[k];
      m_y[k] = RV[k];
      m_r[k] = 8'h00;
      m_f[k] = 8'h00;
      m_c[k] = 1'b0;
      for (int b = 0; b < 8; b++) run[k][b] = 0;
    end
    rst = 1'b1;
    d   = 8'h05;
    @(negedge clk);

    // Reset value held against opposite data, then release.
    cyc(8'h05, 1'b1, 3);
    cyc(8'h05, 1'b0, 6);
    // Latency steps and all-bits toggles.
    cyc(8'h00, 1'b0, 10);
    cyc(8'h03, 1'b0, 10);
    cyc(8'h00, 1'b0, 10);
    cyc(8'hFF, 1'b0, 10);
    cyc(8'h00, 1'b0, 10);
    // Short glitch on the FILT_CYC=4 channel, then a long pulse.
    cyc(8'h04, 1'b0, 3);
    cyc(8'h00, 1'b0, 8);
    cyc(8'h04, 1'b0, 12);
    cyc(8'h00, 1'b0, 12);
    // Count restart on the FILT_CYC=5 channel.
    cyc(8'h08, 1'b0, 4);
    cyc(8'h00, 1'b0, 1);
    cyc(8'h08, 1'b0, 12);
    cyc(8'h00, 1'b0, 12);
    // Reset while the filter is mid-count.
    cyc(8'h04, 1'b0, 5);
    cyc(8'h04, 1'b1, 1);
    cyc(8'h04, 1'b0, 14);

    v = 8'h00;
    for (int s = 0; s < 1500; s++) begin
      int len;
      v   = v ^ 8'($urandom);
      len = int'($urandom_range(1, 9));
      for (int i = 0; i < len; i++) begin
        cyc(v, ($urandom_range(0, 39) == 0), 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
